// File: rtl/fir_out_fifo_if.sv
// fir_out_fifo_if: AXI-Stream bundle around the output FIFO.
//   s_t*  : upstream stream (FIR sm_t*) into the FIFO
//   m_t*  : downstream stream out of the FIFO
// Modports:
//   slave  : FIFO view (accepts s_t*, drives m_t*)
//   master : environment view (drives s_t*, accepts m_t*)
interface fir_out_fifo_if #(
  parameter int unsigned pDATA_WIDTH = 32
);
  logic                   s_tvalid;
  logic [pDATA_WIDTH-1:0] s_tdata;
  logic                   s_tlast;
  logic                   s_tready;
  logic                   m_tvalid;
  logic [pDATA_WIDTH-1:0] m_tdata;
  logic                   m_tlast;
  logic                   m_tready;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: synchronous AXI-Stream FIFO behind the FIR output stream.
// First-word fall-through output register, circular RAM with extended
// pointers, registered s_tready, and per-frame status.
// Ports:
//   axis_clk    : clock, rising edge
//   axis_rst_n  : asynchronous active-low reset
//   bus         : stream bundle (slave modport): s_t* in, m_t* out
//   count       : entries held, output register included
//   frame_done  : one-cycle pulse after the tlast beat leaves
//   beat_cnt    : beats output in the current frame (saturating)
module fir_out_fifo #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pDEPTH_LOG2 = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  fir_out_fifo_if.slave          bus,
  output logic [pDEPTH_LOG2:0]   count,
  output logic                   frame_done,
  output logic [31:0]            beat_cnt
);

  localparam int unsigned DEPTH = 1 << pDEPTH_LOG2;
  localparam logic [pDEPTH_LOG2:0] DEPTH_C = (pDEPTH_LOG2+1)'(DEPTH);
  localparam logic [pDEPTH_LOG2:0] ONE_C   = (pDEPTH_LOG2+1)'(1);

  logic [pDATA_WIDTH:0]   mem_q [DEPTH];
  logic [pDEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q;
  logic [pDEPTH_LOG2:0]   count_q, count_d;
  logic                   s_tready_q, s_tready_d;
  logic                   m_tvalid_q;
  logic [pDATA_WIDTH-1:0] m_tdata_q;
  logic                   m_tlast_q;
  logic                   frame_done_q;
  logic                   last_popped_q;
  logic [31:0]            beat_cnt_q, beat_cnt_d;

  logic push, pop, ram_empty, out_load, ram_pop, bypass, ram_push;

  assign push      = bus.s_tvalid && s_tready_q;
  assign pop       = m_tvalid_q && bus.m_tready;
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign out_load  = !m_tvalid_q || bus.m_tready;
  assign ram_pop   = out_load && !ram_empty;
  // An incoming beat skips the RAM when it would be the next word out anyway;
  // this gives the one-cycle push-to-valid latency from empty.
  assign bypass    = out_load && ram_empty && push;
  assign ram_push  = push && !bypass;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Capacity counts the output register, so the RAM itself never overfills.
  assign s_tready_d = (count_d < DEPTH_C);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      if (last_popped_q)
        beat_cnt_d = 32'd1;
      else if (beat_cnt_q != '1)
        beat_cnt_d = beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (ram_push)
      mem_q[wr_ptr_q[pDEPTH_LOG2-1:0]] <= {bus.s_tlast, bus.s_tdata};
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      s_tready_q    <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tdata_q     <= '0;
      m_tlast_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      last_popped_q <= 1'b0;
      beat_cnt_q    <= '0;
    end else begin
      count_q      <= count_d;
      s_tready_q   <= s_tready_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= pop && m_tlast_q;
      if (pop)
        last_popped_q <= m_tlast_q;
      if (ram_push)
        wr_ptr_q <= wr_ptr_q + ONE_C;
      if (ram_pop) begin
        rd_ptr_q   <= rd_ptr_q + ONE_C;
        m_tvalid_q <= 1'b1;
        {m_tlast_q, m_tdata_q} <= mem_q[rd_ptr_q[pDEPTH_LOG2-1:0]];
      end else if (bypass) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= bus.s_tdata;
        m_tlast_q  <= bus.s_tlast;
      end else if (out_load) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign bus.s_tready = s_tready_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tlast  = m_tlast_q;
  assign count        = count_q;
  assign frame_done   = frame_done_q;
  assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_fir_out_fifo.sv
// tb_fir_out_fifo: randomized bench for fir_out_fifo with a queue-based
// reference model of the FIFO contents and frame counters.
module tb_fir_out_fifo;

  logic        axis_clk;
  logic        axis_rst_n;
  logic [4:0]  count;
  logic        frame_done;
  logic [31:0] beat_cnt;

  fir_out_fifo_if #(.pDATA_WIDTH(32)) bus ();

  fir_out_fifo #(.pDATA_WIDTH(32), .pDEPTH_LOG2(4)) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .bus        (bus.slave),
    .count      (count),
    .frame_done (frame_done),
    .beat_cnt   (beat_cnt)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: everything accepted and not yet delivered, oldest first.
  logic [32:0] model_q[$];
  logic [31:0] exp_beat;
  logic        exp_prev_last;
  logic        exp_fd;

  task automatic model_reset();
    model_q.delete();
    exp_beat      = '0;
    exp_prev_last = 1'b0;
    exp_fd        = 1'b0;
  endtask

  // Advance one clock; inputs are already applied. Returns the transfers that
  // happened and, on a pop, the beat the model says should have left.
  task automatic step(output bit pushed, output bit popped,
                      output logic [32:0] exp_pop, output logic [32:0] obs_pop);
    pushed  = bus.s_tvalid && bus.s_tready;
    popped  = bus.m_tvalid && bus.m_tready;
    obs_pop = {bus.m_tlast, bus.m_tdata};
    exp_pop = '0;
    exp_fd  = 1'b0;
    if (popped) begin
      if (model_q.size() > 0) exp_pop = model_q.pop_front();
      else                    exp_pop = ~obs_pop;
      if (exp_prev_last)               exp_beat = 32'd1;
      else if (exp_beat != 32'hFFFF_FFFF) exp_beat = exp_beat + 32'd1;
      exp_prev_last = exp_pop[32];
      exp_fd        = exp_pop[32];
    end
    if (pushed) model_q.push_back({bus.s_tlast, bus.s_tdata});
    @(posedge axis_clk);
    @(negedge axis_clk);
  endtask

  task automatic test_reset();
    axis_rst_n   = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b0;
    model_reset();
    repeat (2) @(negedge axis_clk);
    checks++;
    if (bus.s_tready !== 1'b0 || bus.m_tvalid !== 1'b0 || bus.m_tdata !== 32'd0 ||
        bus.m_tlast !== 1'b0 || count !== 5'd0 || frame_done !== 1'b0 || beat_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: s_tready=%b m_tvalid=%b m_tdata=%h m_tlast=%b count=%0d fd=%b beat=%0d, required 0 0 0 0 0 0 0",
               bus.s_tready, bus.m_tvalid, bus.m_tdata, bus.m_tlast, count, frame_done, beat_cnt);
    end
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    checks++;
    if (bus.s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: s_tready=%b required 1", bus.s_tready);
    end
  endtask

  task automatic test_pass_through();
    logic [31:0] data [600];
    int sent = 0, recv = 0, cyc = 0, fd_cnt = 0, last_cnt = 0, max_cnt = 0, drops = 0, bad = 0;
    bit pu, po;
    logic [32:0] e, o;
    for (int i = 0; i < 600; i++) data[i] = $urandom;
    bus.m_tready = 1'b1;
    while (recv < 600 && cyc < 2000) begin
      bus.s_tvalid = (sent < 600);
      bus.s_tdata  = (sent < 600) ? data[sent] : 32'd0;
      bus.s_tlast  = (sent == 599);
      if (sent < 600 && bus.s_tready !== 1'b1) drops++;
      step(pu, po, e, o);
      cyc++;
      if (pu) sent++;
      if (po) begin
        if (o !== e || o[31:0] !== data[recv]) begin
          bad++;
          if (bad < 5) $display("FAIL pass_data[%0d]: got %h required %h", recv, o, {recv == 599, data[recv]});
        end
        if (o[32]) last_cnt++;
        recv++;
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    bus.s_tvalid = 1'b0;
    repeat (2) begin
      step(pu, po, e, o);
      if (frame_done === 1'b1) fd_cnt++;
    end
    checks++;
    if (recv != 600 || bad != 0) begin
      errors++;
      $display("FAIL pass_order: received %0d with %0d bad beats, required 600 with 0", recv, bad);
    end
    checks++;
    if (last_cnt != 1 || fd_cnt != 1) begin
      errors++;
      $display("FAIL pass_frame: tlast beats %0d frame_done pulses %0d, required 1 and 1", last_cnt, fd_cnt);
    end
    checks++;
    if (beat_cnt !== 32'd600) begin
      errors++;
      $display("FAIL pass_beat_cnt: got %0d required 600", beat_cnt);
    end
    checks++;
    if (drops != 0 || max_cnt > 2) begin
      errors++;
      $display("FAIL pass_flow: s_tready drops %0d max count %0d, required 0 and <=2", drops, max_cnt);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, recv = 0, cyc = 0, gaps = 0, bad = 0;
    bit pu, po;
    logic [32:0] e, o;
    bus.m_tready = 1'b0;
    repeat (25) begin
      bus.s_tvalid = (sent < 20);
      bus.s_tdata  = 32'(sent + 1);
      bus.s_tlast  = 1'b0;
      step(pu, po, e, o);
      if (pu) sent++;
    end
    checks++;
    if (sent != 16 || count !== 5'd16 || bus.s_tready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: accepted %0d count %0d s_tready %b, required 16 16 0", sent, count, bus.s_tready);
    end
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'd1) begin
      errors++;
      $display("FAIL bp_hold: m_tvalid %b m_tdata %0d, required 1 and 1", bus.m_tvalid, bus.m_tdata);
    end
    bus.m_tready = 1'b1;
    while (recv < 20 && cyc < 100) begin
      bus.s_tvalid = (sent < 20);
      bus.s_tdata  = 32'(sent + 1);
      if (bus.m_tvalid !== 1'b1) gaps++;
      step(pu, po, e, o);
      cyc++;
      if (pu) sent++;
      if (po) begin
        if (o !== e || o[31:0] !== 32'(recv + 1)) begin
          bad++;
          $display("FAIL bp_data[%0d]: got %0d required %0d", recv, o[31:0], recv + 1);
        end
        recv++;
      end
    end
    bus.s_tvalid = 1'b0;
    checks++;
    if (recv != 20 || bad != 0 || gaps != 0) begin
      errors++;
      $display("FAIL bp_drain: received %0d bad %0d gaps %0d, required 20 0 0", recv, bad, gaps);
    end
  endtask

  task automatic test_full_simul();
    int cyc = 0, pops = 0, bad = 0, out_range = 0, val = 1000;
    bit pu, po;
    logic [32:0] e, o;
    bus.m_tready = 1'b0;
    bus.s_tlast  = 1'b0;
    while (bus.s_tready === 1'b1 && cyc < 40) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = 32'(val);
      step(pu, po, e, o);
      cyc++;
      if (pu) val++;
    end
    checks++;
    if (count !== 5'd16) begin
      errors++;
      $display("FAIL full_fill: count %0d required 16", count);
    end
    bus.m_tready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = 32'(val);
      step(pu, po, e, o);
      if (pu) val++;
      if (po) begin
        pops++;
        if (o !== e) begin
          bad++;
          if (bad < 5) $display("FAIL full_data: got %h required %h", o, e);
        end
      end
      if (count < 5'd15 || count > 5'd16) out_range++;
    end
    checks++;
    if (pops < 30 || bad != 0) begin
      errors++;
      $display("FAIL full_throughput: pops %0d bad %0d over 60 cycles, required >=30 and 0", pops, bad);
    end
    checks++;
    if (out_range != 0) begin
      errors++;
      $display("FAIL full_count_range: %0d cycles outside 15..16, required 0", out_range);
    end
    bus.s_tvalid = 1'b0;
    cyc = 0;
    bad = 0;
    while (model_q.size() > 0 && cyc < 100) begin
      step(pu, po, e, o);
      cyc++;
      if (po && o !== e) bad++;
    end
    checks++;
    if (bad != 0 || bus.m_tvalid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL full_drain: bad %0d m_tvalid %b count %0d, required 0 0 0", bad, bus.m_tvalid, count);
    end
  endtask

  task automatic test_negative();
    logic [31:0] vals [3];
    int sent = 0, recv = 0, cyc = 0;
    bit pu, po;
    logic [32:0] e, o;
    vals[0] = -32'sd10;
    vals[1] = 32'h8000_0000;
    vals[2] = 32'h7FFF_FFFF;
    bus.m_tready = 1'b1;
    while (recv < 3 && cyc < 20) begin
      bus.s_tvalid = (sent < 3);
      bus.s_tdata  = (sent < 3) ? vals[sent] : 32'd0;
      bus.s_tlast  = (sent == 2);
      step(pu, po, e, o);
      cyc++;
      if (pu) sent++;
      if (po) begin
        checks++;
        if (o !== e || $signed(o[31:0]) !== $signed(vals[recv])) begin
          errors++;
          $display("FAIL neg_value[%0d]: got %0d required %0d", recv, $signed(o[31:0]), $signed(vals[recv]));
        end
        recv++;
      end
    end
    bus.s_tvalid = 1'b0;
    checks++;
    if (recv != 3) begin
      errors++;
      $display("FAIL neg_count: received %0d required 3", recv);
    end
  endtask

  task automatic test_reset_mid_frame();
    int sent = 0, recv = 0, cyc = 0, bad = 0;
    bit pu, po;
    logic [32:0] e, o;
    bus.m_tready = 1'b0;
    bus.s_tlast  = 1'b0;
    while (sent < 5 && cyc < 20) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = 32'(500 + sent);
      step(pu, po, e, o);
      cyc++;
      if (pu) sent++;
    end
    bus.s_tvalid = 1'b0;
    #2;
    axis_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.m_tvalid !== 1'b0 || count !== 5'd0 || bus.s_tready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: m_tvalid %b count %0d s_tready %b, required 0 0 0", bus.m_tvalid, count, bus.s_tready);
    end
    model_reset();
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    sent = 0;
    cyc  = 0;
    bus.m_tready = 1'b1;
    while (cyc < 20) begin
      bus.s_tvalid = (sent < 3);
      bus.s_tdata  = 32'(900 + sent);
      bus.s_tlast  = (sent == 2);
      step(pu, po, e, o);
      cyc++;
      if (pu) sent++;
      if (po) begin
        if (o !== e || o[31:0] !== 32'(900 + recv)) begin
          bad++;
          $display("FAIL midreset_data[%0d]: got %0d required %0d", recv, o[31:0], 900 + recv);
        end
        recv++;
      end
    end
    bus.s_tvalid = 1'b0;
    checks++;
    if (recv != 3 || bad != 0 || beat_cnt !== 32'd3) begin
      errors++;
      $display("FAIL midreset_frame: beats %0d bad %0d beat_cnt %0d, required 3 0 3", recv, bad, beat_cnt);
    end
  endtask

  task automatic test_random();
    int sent = 0, recv = 0, cyc = 0, bad = 0, fd_cnt = 0, fd_bad = 0, stall_bad = 0, state_bad = 0;
    bit pu, po, stalled;
    logic [32:0] e, o, held;
    logic [31:0] cur;
    cur = $urandom;
    while (recv < 1000 && cyc < 20000) begin
      bus.s_tvalid = (sent < 1000) && ($urandom_range(1, 0) == 1);
      bus.s_tdata  = cur;
      bus.s_tlast  = (sent % 100 == 99);
      bus.m_tready = ($urandom_range(1, 0) == 1);
      stalled = bus.m_tvalid && !bus.m_tready;
      held    = {bus.m_tlast, bus.m_tdata};
      step(pu, po, e, o);
      cyc++;
      if (pu) begin
        sent++;
        cur = $urandom;
      end
      if (po) begin
        if (o !== e) begin
          bad++;
          if (bad < 5) $display("FAIL rand_data[%0d]: got %h required %h", recv, o, e);
        end
        recv++;
      end
      if (stalled && (bus.m_tvalid !== 1'b1 || {bus.m_tlast, bus.m_tdata} !== held)) stall_bad++;
      if (frame_done === 1'b1) fd_cnt++;
      if (frame_done !== exp_fd || beat_cnt !== exp_beat) fd_bad++;
      if (int'(count) != model_q.size() || bus.m_tvalid !== (model_q.size() > 0) ||
          bus.s_tready !== (model_q.size() < 16)) state_bad++;
    end
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b1;
    repeat (2) begin
      step(pu, po, e, o);
      if (frame_done === 1'b1) fd_cnt++;
    end
    checks++;
    if (recv != 1000 || bad != 0) begin
      errors++;
      $display("FAIL rand_scoreboard: received %0d bad %0d, required 1000 and 0", recv, bad);
    end
    checks++;
    if (fd_cnt != 10 || fd_bad != 0) begin
      errors++;
      $display("FAIL rand_frames: frame_done pulses %0d status mismatches %0d, required 10 and 0", fd_cnt, fd_bad);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL rand_stall_stable: %0d unstable stalled cycles, required 0", stall_bad);
    end
    checks++;
    if (state_bad != 0) begin
      errors++;
      $display("FAIL rand_occupancy: %0d cycles with count/valid/ready off model, required 0", state_bad);
    end
    checks++;
    if (beat_cnt !== 32'd100) begin
      errors++;
      $display("FAIL rand_beat_cnt: got %0d required 100", beat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_full_simul();
    test_negative();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_fifo.md
Name: fir_out_fifo

Overview:
- Synchronous AXI-Stream FIFO placed directly downstream of the FIR's output stream (sm_t*). It decouples FIR output timing from the consumer.
- It absorbs consumer back-pressure so the FIR pipeline keeps running, and it carries the frame-end marker (tlast) through unchanged.
- It reports occupancy, per-frame beat count and a frame-done pulse for the control/status logic.

Parameters:
- pDATA_WIDTH, 32, stream data width in bits.
- pDEPTH_LOG2, 4, log2 of storage depth; depth = 2**pDEPTH_LOG2 entries (default 16).

Ports:
- axis_clk  in  1  sole clock; all logic on rising edge.
- axis_rst_n  in  1  asynchronous, active-low reset.
- s_tvalid  in  1  upstream beat valid (from FIR sm_tvalid).
- s_tdata  in  pDATA_WIDTH  upstream signed sample (from FIR sm_tdata).
- s_tlast  in  1  upstream frame end (from FIR sm_tlast).
- s_tready  out  1  FIFO can accept (drives FIR sm_tready).
- m_tvalid  out  1  output beat valid.
- m_tdata  out  pDATA_WIDTH  output sample.
- m_tlast  out  1  output frame end.
- m_tready  in  1  downstream accepts.
- count  out  pDEPTH_LOG2+1  entries held, including the output register.
- frame_done  out  1  one-cycle pulse after the tlast beat is accepted downstream.
- beat_cnt  out  32  beats output in the current frame; holds the final frame length after tlast.

Behaviour:
- Reset (async assert, sync release):
  - s_tready=0 while axis_rst_n=0, then 1 from the first clock edge after release.
  - m_tvalid=0, m_tdata=0, m_tlast=0, count=0, frame_done=0, beat_cnt=0.
  - Read/write pointers are cleared.
  - Reset mid-frame discards all stored beats; no partial output follows.
- Storage:
  - Circular RAM of 2**pDEPTH_LOG2 words, each pDATA_WIDTH+1 bits (data + tlast).
  - Write/read pointers are pDEPTH_LOG2+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo 2**pDEPTH_LOG2 with the MSB toggling on wrap.
- Push: occurs when s_tvalid && s_tready at a rising edge. s_tdata/s_tlast are written at wr_ptr, then wr_ptr+1.
- s_tready:
  - Registered: s_tready = (count < depth) on the next cycle.
  - It must not depend combinationally on m_tready.
  - When count reaches depth, s_tready drops in the same cycle count updates; no beat is ever lost or overwritten.
- Output register (first-word fall-through):
  - Loads from RAM when m_tvalid=0 or (m_tvalid && m_tready), and RAM is non-empty.
  - Latency from a push into an empty FIFO to m_tvalid=1 is 1 cycle; data appears the cycle after s_tvalid&&s_tready.
  - m_tdata/m_tlast stay stable while m_tvalid && !m_tready.
  - m_tvalid drops only after acceptance with no further data.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, a pop in cycle N makes s_tready=1 in cycle N+1.
- Empty: no pop; m_tvalid=0.
- Full: no push; s_tready=0.
- Ordering: strict FIFO; data and tlast are passed bit-exact, with no sign or width conversion.
- beat_cnt:
  - Increments on each m_tvalid&&m_tready.
  - On a beat with m_tlast=1 it takes its final value (the frame length).
  - It restarts at 1 on the first accepted beat of the next frame.
  - Saturates at 2**32-1.
- frame_done:
  - Registered.
  - High exactly one cycle, in the cycle after the m_tlast beat handshake.

Test Plan:
- Pass-through: 600 samples, s_tvalid always 1, m_tready always 1, tlast on beat 599.
  - Every output equals its input, in order.
  - m_tlast only on beat 599; frame_done pulses once; beat_cnt=600.
  - s_tready never drops; count ≤ 2.
- Back-pressure fill: m_tready=0, push 20 beats (values 1..20).
  - s_tready falls after 16 accepted; count=16.
  - m_tdata holds 1.
  - Then m_tready=1: outputs 1..20 with no gap once refilled; no loss.
- Simultaneous at full: FIFO full, m_tready=1 and s_tvalid=1 every cycle.
  - Throughput 1 beat per 2 cycles or better.
  - count stays in 15..16; data order preserved across pointer wrap (≥40 beats, covering 2+ wraps).
- Negative values: input -10, -2147483648, 2147483647 → identical signed output values.
- Reset mid-frame: 5 beats stored, assert axis_rst_n=0 asynchronously between edges.
  - m_tvalid=0 and count=0 immediately.
  - After release, a new 3-beat frame outputs only those 3 beats; beat_cnt=3.
- Random ready/valid: 1000 beats with random s_tvalid/m_tready at 50% each, tlast every 100 beats.
  - Scoreboard matches every beat.
  - frame_done count=10; m_tdata stable whenever stalled.
